// File: rtl/nested_cnt_en_pkg.sv
// ---------------------------------------------------------------------------
// fc_cnt_pkg
//
// Shared definitions for the nested-loop tile-index counter (nested_cnt_en)
// and its per-channel stage (cnt_stage).
//
// Contents:
//   cnt_state_e     - traversal FSM states (idle / running / done pulse)
//   CNT_WIDTH_DEF   - default bits per channel counter; follows the
//                     design-wide input width FC_IN_WIDTH
//   CNT_NUM_CH_DEF  - default number of nested channels
// ---------------------------------------------------------------------------
`ifndef FC_IN_WIDTH
`define FC_IN_WIDTH 8
`endif

package fc_cnt_pkg;

  localparam int CNT_WIDTH_DEF = `FC_IN_WIDTH;

  localparam int CNT_NUM_CH_DEF = 3;

  typedef enum logic [1:0] {
    CNT_IDLE,
    CNT_RUN,
    CNT_DONE
  } cnt_state_e;

endpackage

// File: rtl/nested_cnt_en_cnt_stage.sv
// ---------------------------------------------------------------------------
// cnt_stage
//
// One channel of the nested counter: a count register plus the limit that
// was captured when the traversal started.
//
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset (count and limit to 0)
//   clr      in  synchronous clear of the count, highest priority
//   load     in  capture limit and zero the count (accepted start)
//   carry_in in  advance this channel on this edge (already gated by
//                busy & enable and by all inner channels being at limit)
//   limit    in  terminal value, inclusive
//   cnt      out current count
//   at_lim   out count equals captured limit
//   wrap     out channel returns to 0 on this edge
// ---------------------------------------------------------------------------
module cnt_stage
  import fc_cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             at_lim,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] lim_q;

  // Equality compare only: a limit of all-ones wraps through the normal
  // reset-to-zero path, so no extra overflow bit is needed.
  assign at_lim = (cnt == lim_q);
  assign wrap   = carry_in & at_lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      lim_q <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      lim_q <= limit;
      cnt   <= '0;
    end else if (carry_in) begin
      cnt <= at_lim ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/nested_cnt_en.sv
// ---------------------------------------------------------------------------
// nested_cnt_en
//
// Parametrised nested-loop counter for the FC datapath controller. NUM_CH
// counters of WIDTH bits are chained so that channel i+1 advances when
// channel i wraps (channel 0 innermost). A start/busy/done FSM frames one
// full traversal of prod(limit[i]+1) steps.
//
// Optional feature: define FC_CNT_GRAY_EN to add gray_out, a Gray-coded copy
// of each channel count for clock-domain handoff of tile indices.
//
// Ports:
//   clk       in  clock
//   rst_n     in  asynchronous active-low reset
//   clr       in  synchronous abort/clear, overrides start and enable
//   start     in  begin a traversal (IDLE only); samples limit
//   enable    in  advance one step (RUN only)
//   limit     in  NUM_CH x WIDTH per-channel inclusive terminal values
//   cnt_out   out NUM_CH x WIDTH current channel counts
//   wrap      out NUM_CH per-channel wrap on this step (combinational)
//   busy      out FSM in RUN
//   done      out one-cycle pulse after the final step
//   gray_out  out NUM_CH x WIDTH Gray counts (FC_CNT_GRAY_EN only)
// ---------------------------------------------------------------------------
module nested_cnt_en
  import fc_cnt_pkg::*;
#(
  parameter int WIDTH  = CNT_WIDTH_DEF,
  parameter int NUM_CH = CNT_NUM_CH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    start,
  input  logic                    enable,
  input  logic [NUM_CH*WIDTH-1:0] limit,
  output logic [NUM_CH*WIDTH-1:0] cnt_out,
  output logic [NUM_CH-1:0]       wrap,
  output logic                    busy,
  output logic                    done
`ifdef FC_CNT_GRAY_EN
  ,
  output logic [NUM_CH*WIDTH-1:0] gray_out
`endif
);

  cnt_state_e        state_q;
  cnt_state_e        state_d;
  logic              load;
  logic              final_step;
  logic [NUM_CH-1:0] carry;
  logic [NUM_CH-1:0] at_lim;

  // -------------------------------------------------------------------------
  // Traversal FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CNT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      CNT_IDLE: begin
        if (start) begin
          state_d = CNT_RUN;
          load    = 1'b1;
        end
      end
      CNT_RUN: begin
        busy = 1'b1;
        if (final_step) begin
          state_d = CNT_DONE;
        end
      end
      CNT_DONE: begin
        done    = 1'b1;
        state_d = CNT_IDLE;
      end
      default: begin
        state_d = CNT_IDLE;
      end
    endcase
    // Abort wins over everything; a clear on the final step lands in IDLE
    // so the done pulse never appears.
    if (clr) begin
      state_d = CNT_IDLE;
      load    = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Carry chain: a channel advances only when every inner channel sits at
  // its limit. The outermost channel wrapping implies all channels wrap,
  // which is exactly the final step of the traversal.
  // -------------------------------------------------------------------------
  assign carry[0]   = busy & enable;
  assign final_step = wrap[NUM_CH-1];

  for (genvar i = 1; i < NUM_CH; i++) begin : g_carry
    assign carry[i] = carry[i-1] & at_lim[i-1];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cnt_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .load     (load),
      .carry_in (carry[i]),
      .limit    (limit[i*WIDTH +: WIDTH]),
      .cnt      (cnt_out[i*WIDTH +: WIDTH]),
      .at_lim   (at_lim[i]),
      .wrap     (wrap[i])
    );
  end

`ifdef FC_CNT_GRAY_EN
  // Gray encoding of the registered count, so a reader in another clock
  // domain sees at most one bit change per step.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_gray
    logic [WIDTH-1:0] bin;
    assign bin                        = cnt_out[i*WIDTH +: WIDTH];
    assign gray_out[i*WIDTH +: WIDTH] = bin ^ (bin >> 1);
  end
`endif

endmodule

// File: tb/tb_nested_cnt_en.sv
// ---------------------------------------------------------------------------
// tb_nested_cnt_en
//
// Self-checking bench for nested_cnt_en (WIDTH=8, NUM_CH=3). A table of
// per-cycle vectors covers idle behaviour, ignored inputs and clear
// collisions; hand-written loops cover full traversals, gapped enables,
// asynchronous reset and (with FC_CNT_GRAY_EN) the Gray output.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_nested_cnt_en;

  localparam int W  = 8;
  localparam int NC = 3;

  logic            clk;
  logic            rst_n;
  logic            clr;
  logic            start;
  logic            enable;
  logic [NC*W-1:0] limit;
  logic [NC*W-1:0] cnt_out;
  logic [NC-1:0]   wrap;
  logic            busy;
  logic            done;
`ifdef FC_CNT_GRAY_EN
  logic [NC*W-1:0] gray_out;
`endif

  int vec_count;
  int miscompares;

  nested_cnt_en #(
    .WIDTH  (W),
    .NUM_CH (NC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .start    (start),
    .enable   (enable),
    .limit    (limit),
    .cnt_out  (cnt_out),
    .wrap     (wrap),
    .busy     (busy),
    .done     (done)
`ifdef FC_CNT_GRAY_EN
    ,
    .gray_out (gray_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic            start;
    logic            enable;
    logic            clr;
    logic [NC*W-1:0] limit;
    logic [NC*W-1:0] exp_cnt;
    logic [NC-1:0]   exp_wrap;
    logic            exp_busy;
    logic            exp_done;
  } vec_t;

  function automatic vec_t mkVec(input logic st, input logic en, input logic cl,
                                 input logic [NC*W-1:0] lim, input logic [NC*W-1:0] ec,
                                 input logic [NC-1:0] ew, input logic eb, input logic ed);
    vec_t v;
    v.start    = st;
    v.enable   = en;
    v.clr      = cl;
    v.limit    = lim;
    v.exp_cnt  = ec;
    v.exp_wrap = ew;
    v.exp_busy = eb;
    v.exp_done = ed;
    return v;
  endfunction

  task automatic applyStimulus(input logic st, input logic en, input logic cl,
                               input logic [NC*W-1:0] lim);
    @(negedge clk);
    start  = st;
    enable = en;
    clr    = cl;
    limit  = lim;
  endtask

  task automatic checkOutput(input string name, input logic [NC*W-1:0] ec,
                             input logic [NC-1:0] ew, input logic eb, input logic ed);
    logic bad;
    string gmsg;
`ifdef FC_CNT_GRAY_EN
    logic [NC*W-1:0] eg;
`endif
    #1;
    bad  = (cnt_out !== ec) || (wrap !== ew) || (busy !== eb) || (done !== ed);
    gmsg = "";
`ifdef FC_CNT_GRAY_EN
    for (int i = 0; i < NC; i++) begin
      eg[i*W +: W] = ec[i*W +: W] ^ (ec[i*W +: W] >> 1);
    end
    if (gray_out !== eg) bad = 1'b1;
    gmsg = $sformatf(" gray_out=%h (want %h)", gray_out, eg);
`endif
    vec_count++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL %s: got cnt_out=%h wrap=%b busy=%b done=%b, want cnt_out=%h wrap=%b busy=%b done=%b%s",
               name, cnt_out, wrap, busy, done, ec, ew, eb, ed, gmsg);
    end
  endtask

  // One traversal from IDLE: start, then exp_steps accepted enables, then
  // the done cycle and a return to IDLE. Expected counts and wraps come from
  // the mixed-radix position k of the traversal. In gapped mode enable drops
  // every third cycle, start is pulsed mid-run and limit is inverted after
  // start, none of which may affect the latched traversal.
  task automatic runTraversal(input string name, input logic [NC*W-1:0] lim,
                              input int exp_steps, input bit gapped);
    int l0, l1, p0, p01, k, cyc;
    logic en, st;
    logic [NC*W-1:0] ec, cur_lim;
    logic [NC-1:0] ew;
    l0  = int'(lim[7:0]);
    l1  = int'(lim[15:8]);
    p0  = l0 + 1;
    p01 = p0 * (l1 + 1);
    applyStimulus(1'b1, 1'b0, 1'b0, lim);
    checkOutput({name, "_start"}, '0, '0, 1'b0, 1'b0);
    k   = 0;
    cyc = 0;
    while (k < exp_steps) begin
      en      = gapped ? (cyc % 3 != 1) : 1'b1;
      st      = gapped && (cyc % 4 == 2);
      cur_lim = (gapped && cyc > 0) ? ~lim : lim;
      applyStimulus(st, en, 1'b0, cur_lim);
      ec = {8'(k / p01), 8'((k / p0) % (l1 + 1)), 8'(k % p0)};
      ew = '0;
      if (en) begin
        ew[0] = ((k + 1) % p0 == 0);
        ew[1] = ((k + 1) % p01 == 0);
        ew[2] = (k + 1 == exp_steps);
      end
      checkOutput($sformatf("%s_step%0d", name, k), ec, ew, 1'b1, 1'b0);
      if (en) k++;
      cyc++;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, lim);
    checkOutput({name, "_done"}, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, lim);
    checkOutput({name, "_idle"}, '0, '0, 1'b0, 1'b0);
  endtask

  localparam logic [NC*W-1:0] L_SMALL = 24'h01_00_01;

  vec_t vecs[20];

  initial begin
    vec_count   = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clr         = 1'b0;
    start       = 1'b0;
    enable      = 1'b0;
    limit       = '0;

    // Idle behaviour, clear collisions and ignored inputs, limits {1,0,1}.
    vecs[0]  = mkVec(0, 1, 0, L_SMALL, 24'h000000, 3'b000, 0, 0);
    vecs[1]  = mkVec(0, 1, 0, L_SMALL, 24'h000000, 3'b000, 0, 0);
    vecs[2]  = mkVec(1, 0, 1, L_SMALL, 24'h000000, 3'b000, 0, 0);
    vecs[3]  = mkVec(0, 1, 0, L_SMALL, 24'h000000, 3'b000, 0, 0);
    vecs[4]  = mkVec(1, 0, 0, L_SMALL, 24'h000000, 3'b000, 0, 0);
    vecs[5]  = mkVec(0, 1, 0, L_SMALL, 24'h000000, 3'b000, 1, 0);
    vecs[6]  = mkVec(0, 0, 0, L_SMALL, 24'h000001, 3'b000, 1, 0);
    vecs[7]  = mkVec(1, 1, 0, 24'h0,   24'h000001, 3'b011, 1, 0);
    vecs[8]  = mkVec(0, 1, 0, 24'h0,   24'h010000, 3'b000, 1, 0);
    vecs[9]  = mkVec(0, 1, 0, L_SMALL, 24'h010001, 3'b111, 1, 0);
    vecs[10] = mkVec(0, 1, 0, L_SMALL, 24'h000000, 3'b000, 0, 1);
    vecs[11] = mkVec(1, 0, 0, 24'h0,   24'h000000, 3'b000, 0, 0);
    vecs[12] = mkVec(0, 1, 0, 24'h0,   24'h000000, 3'b111, 1, 0);
    vecs[13] = mkVec(0, 0, 0, 24'h0,   24'h000000, 3'b000, 0, 1);
    vecs[14] = mkVec(1, 0, 0, L_SMALL, 24'h000000, 3'b000, 0, 0);
    vecs[15] = mkVec(0, 1, 0, L_SMALL, 24'h000000, 3'b000, 1, 0);
    vecs[16] = mkVec(0, 1, 0, L_SMALL, 24'h000001, 3'b011, 1, 0);
    vecs[17] = mkVec(0, 1, 0, L_SMALL, 24'h010000, 3'b000, 1, 0);
    vecs[18] = mkVec(0, 1, 1, L_SMALL, 24'h010001, 3'b111, 1, 0);
    vecs[19] = mkVec(0, 1, 0, L_SMALL, 24'h000000, 3'b000, 0, 0);

    #12;
    checkOutput("reset_hold", '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].start, vecs[i].enable, vecs[i].clr, vecs[i].limit);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_wrap,
                  vecs[i].exp_busy, vecs[i].exp_done);
    end

    runTraversal("sweep_1_2_3", 24'h01_02_03, 24, 1'b0);
    runTraversal("caseA_0_0_255", 24'h00_00_FF, 256, 1'b0);
    runTraversal("caseB_0_0_0", 24'h00_00_00, 1, 1'b0);
    runTraversal("gapped_1_2_3", 24'h01_02_03, 24, 1'b1);

    // Asynchronous reset mid-traversal: outputs clear before any clock edge.
    applyStimulus(1'b1, 1'b0, 1'b0, 24'h03_03_03);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 24'h03_03_03);
    end
    #2;
    rst_n = 1'b0;
    checkOutput("async_reset", '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 24'h03_03_03);
    rst_n = 1'b1;
    checkOutput("after_async_reset", '0, '0, 1'b0, 1'b0);

`ifdef FC_CNT_GRAY_EN
    runTraversal("gray_0_0_7", 24'h00_00_07, 8, 1'b0);
    begin
      logic [W-1:0] prev_g, cur_g;
      applyStimulus(1'b1, 1'b0, 1'b0, 24'h00_00_07);
      #1;
      prev_g = gray_out[W-1:0];
      for (int s = 0; s <= 8; s++) begin
        applyStimulus(1'b0, (s < 8), 1'b0, 24'h00_00_07);
        #1;
        cur_g = gray_out[W-1:0];
        if (s > 0) begin
          vec_count++;
          if ($countones(prev_g ^ cur_g) != 1) begin
            miscompares++;
            $display("[TB] FAIL gray_onebit%0d: got %b -> %b (%0d bits changed), want exactly 1 bit",
                     s, prev_g, cur_g, $countones(prev_g ^ cur_g));
          end
        end
        prev_g = cur_g;
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/nested_cnt_en.md
# nested_cnt_en

Parametrised nested-loop counter: a successor to the single free-running enable counter. It chains `NUM_CH` counters of `WIDTH` bits, each with a programmable inclusive limit, so that channel *i+1* advances when channel *i* wraps. A start/busy/done FSM frames one full traversal. It sits in the FC datapath controller and generates the input/weight/output tile indices that drive the address generators.

## Interface
Parameters:
- `WIDTH`, 8: bits per channel counter.
- `NUM_CH`, 3: number of nested channels. Channel 0 is the innermost.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `clr` in 1: synchronous abort/clear, highest priority.
- `start` in 1: begin a traversal; honoured only in IDLE.
- `enable` in 1: advance one step; honoured only in RUN.
- `limit` in `NUM_CH`×`WIDTH`: per-channel terminal value (inclusive); sampled on accepted `start`.
- `cnt_out` out `NUM_CH`×`WIDTH`: current channel counts.
- `wrap` out `NUM_CH`: channel wraps on this step (combinational).
- `busy` out 1: FSM in RUN.
- `done` out 1: one-cycle pulse after the final step.
- `gray_out` out `NUM_CH`×`WIDTH`: present only with `FC_CNT_GRAY_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`. Latch `limit` into `lim_q` and zero all counts.
  - RUN → DONE on the final step, i.e. `enable` while every channel is at `lim_q`.
  - DONE → IDLE unconditionally after 1 cycle. `done`=1 only in DONE.
- `clr` from any state: go to IDLE, zero all counts, suppress `done`. `clr` overrides a simultaneous `start` or `enable`.
- `start` outside IDLE is ignored. `enable` outside RUN is ignored; counts hold.
- Step rule in RUN with `enable`=1:
  - `carry[0]`=1; `carry[i+1]` = `carry[i]` & (`cnt[i]`==`lim_q[i]`).
  - Channel i with `carry[i]`: if `cnt[i]`==`lim_q[i]`, then `cnt[i]`←0, else `cnt[i]`←`cnt[i]`+1.
  - `wrap[i]` = `busy` & `enable` & `carry[i]` & (`cnt[i]`==`lim_q[i]`).
- Final step: all channels return to 0, and every `wrap` bit is 1 in that cycle.
- Width rules:
  - The compare is equality only; there is no `WIDTH+1` overflow path.
  - `limit`=2^WIDTH−1 is legal and wraps naturally.
  - `limit`=0 makes the channel wrap on every carry-in.
  - Total steps per traversal = Π(`lim_q[i]`+1).
- Changes to `limit` during RUN have no effect until the next `start`.

## Timing
- Reset values: `cnt_out`=0, `lim_q`=0, state IDLE, `busy`=0, `done`=0, `wrap`=0, `gray_out`=0.
- `start` sampled at edge t: `busy`=1 from t+1, and the first `enable` is accepted at edge t+1.
- `cnt_out` is registered and updates at the edge that samples `enable`.
- `wrap` is valid in the same cycle as `enable`, before that edge.
- Final step at edge t: `done`=1 and `busy`=0 during cycle t+1; IDLE from t+2.
- The earliest restart is a `start` sampled at t+2.
- Asserting `rst_n` low mid-traversal clears everything immediately, independent of `clk`.

## Configuration
- `FC_CNT_GRAY_EN` defined:
  - Adds port `gray_out`, with `gray_out[i]` = (`cnt[i]`>>1)^`cnt[i]`.
  - `gray_out` is combinational from the registered count and is used for CDC handoff of tile indices.
- `FC_CNT_GRAY_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `fc_cnt_pkg`:
  - `typedef enum logic [1:0] {CNT_IDLE, CNT_RUN, CNT_DONE} cnt_state_e`.
  - Default `WIDTH` constant, tied to the design-wide input width macro.
  - Default `NUM_CH` constant.
- Sub-module `cnt_stage` is instantiated `NUM_CH` times via generate. It holds one count register and its limit register, takes `carry_in`, `load`, `clr`, and produces `cnt`, `at_lim`, and `wrap`.
- The top level holds the FSM, the carry chain, and the optional Gray encoders.

## Test plan
- Reset and idle:
  - Hold `rst_n`=0, then release. Pulse `enable` 5× in IDLE.
  - Expect `cnt_out` to stay all 0, `busy`=0, `done`=0.
- Nested sweep:
  - `WIDTH`=8, `NUM_CH`=3, `limit`={1,2,3} (ch2,ch1,ch0). `start`, then `enable` held.
  - Expect exactly 24 steps. `wrap[0]` every 4th step; `wrap[1]` every 12th.
  - Expect `done` pulse at the cycle after step 24, with counts all 0.
- Limit-zero and full-range:
  - Case A: `limit`={0,0,255} → 256 steps; `wrap[1]` and `wrap[2]` only on step 256.
  - Case B: `limit`={0,0,0} → `done` after 1 step.
- Gapped enable and ignored inputs:
  - Toggle `enable` 1-0-1. Pulse `start` during RUN. Change `limit` mid-run.
  - Expect counts to hold when `enable`=0, and no restart. The step count must still follow the latched limits.
- Clear collisions:
  - `clr`=1 together with `enable` on the final step → IDLE, counts 0, no `done`.
  - `clr`=1 together with `start` in IDLE → stays IDLE.
- Gray (with `FC_CNT_GRAY_EN`):
  - `limit`={0,0,7}. Every step, check `gray_out[0]` = (`cnt`>>1)^`cnt`.
  - Check that successive values differ in exactly one bit, including the 7→0 wrap (0100→0000).
